// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register-file write port between the
// MEM/WB pipeline and a 2-deep buffer of divider results.
module wb_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int RD_WIDTH     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic                  pipe_we,
  input  logic [RD_WIDTH-1:0]   pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  pipe_hold,
  input  logic                  div_valid,
  input  logic [RD_WIDTH-1:0]   div_rd,
  input  logic [DATA_WIDTH-1:0] div_data,
  output logic                  div_ready,
  output logic                  rf_we,
  output logic [RD_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [1:0]            buf_count
);

  localparam int SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [RD_WIDTH-1:0]   r_rd   [2];
  logic [DATA_WIDTH-1:0] r_data [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic [SW-1:0]         r_starve;

  logic w_pipe_req;
  logic w_div_req;
  logic w_urgent;
  logic w_gnt_pipe;
  logic w_gnt_div;
  logic w_push;
  logic w_pop;

  assign w_pipe_req = pipe_valid & pipe_we;
  assign w_div_req  = (r_count != 2'd0);
  assign w_urgent   = (r_starve >= LIM);
  assign w_gnt_pipe = w_pipe_req & ~w_urgent;
  assign w_gnt_div  = ~w_gnt_pipe & w_div_req;

  // Ready comes from the registered count only, so a full buffer
  // never accepts even when the head is popping this cycle.
  assign div_ready = (r_count < 2'd2);
  assign w_push    = div_valid & div_ready;
  assign w_pop     = w_gnt_div;
  assign pipe_hold = w_pipe_req & w_gnt_div;
  assign buf_count = r_count;

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (1'b1)
      w_gnt_pipe: begin
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end
      w_gnt_div: begin
        rf_waddr = r_rd[r_rptr];
        rf_wdata = r_data[r_rptr];
      end
      default: ;
    endcase
  end

  // x0 targets still consume the grant, they just never write.
  assign rf_we = (w_gnt_pipe | w_gnt_div) & (rf_waddr != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= div_rd;
      r_data[r_wptr] <= div_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_pop || !w_div_req)
        r_starve <= '0;
      else if (w_gnt_pipe && r_starve != LIM)
        r_starve <= r_starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a
// queue-based model of the writeback arbitration rules.
module tb_wb_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid, pipe_we, pipe_hold;
  logic [4:0]  pipe_rd, div_rd, rf_waddr;
  logic [31:0] pipe_data, div_data, rf_wdata;
  logic        div_valid, div_ready, rf_we;
  logic [1:0]  buf_count;

  wb_port_arbiter #(
    .DATA_WIDTH(32), .RD_WIDTH(5), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_we(pipe_we),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_hold(pipe_hold),
    .div_valid(div_valid), .div_rd(div_rd),
    .div_data(div_data), .div_ready(div_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t m_q[$];
  int   m_starve;
  int   checks;
  int   errors;
  logic [4:0] div_log[$];
  logic acc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input logic rn, input logic pv, input logic pw,
                      input logic [4:0] prd, input logic [31:0] pd,
                      input logic dv, input logic [4:0] drd,
                      input logic [31:0] dd);
    bit   preq, gp, gd, push;
    logic [4:0]  ea;
    logic [31:0] ed;
    ent_t e;
    rst_n = rn; pipe_valid = pv; pipe_we = pw;
    pipe_rd = prd; pipe_data = pd;
    div_valid = dv; div_rd = drd; div_data = dd;
    @(negedge clk);
    preq = pv && pw;
    gp = preq && (m_starve < LIM);
    gd = !gp && (m_q.size() > 0);
    ea = gp ? prd : (gd ? m_q[0].rd : 5'd0);
    ed = gp ? pd : (gd ? m_q[0].d : 32'd0);
    chk("rf_waddr", 64'(rf_waddr), 64'(ea));
    chk("rf_wdata", 64'(rf_wdata), 64'(ed));
    chk("rf_we", 64'(rf_we), 64'((gp || gd) && ea != 0));
    chk("pipe_hold", 64'(pipe_hold), 64'(preq && gd));
    chk("div_ready", 64'(div_ready), 64'(m_q.size() < 2));
    chk("buf_count", 64'(buf_count), 64'(m_q.size()));
    acc = dv && (m_q.size() < 2);
    if (pipe_hold) div_log.push_back(rf_waddr);
    if (!rn) begin
      m_q.delete();
      m_starve = 0;
    end else begin
      push = dv && (m_q.size() < 2);
      if (gd || m_q.size() == 0) m_starve = 0;
      else if (gp && m_starve < LIM) m_starve++;
      if (gd) void'(m_q.pop_front());
      if (push) begin
        e.rd = drd; e.d = dd;
        m_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; errors = 0; m_starve = 0;
    rst_n = 0; pipe_valid = 0; pipe_we = 0;
    pipe_rd = 0; pipe_data = 0;
    div_valid = 0; div_rd = 0; div_data = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    idle();
    chk("rst_buf_count", 64'(buf_count), 64'd0);
    chk("rst_div_ready", 64'(div_ready), 64'd1);

    // pipeline-only write
    step(1, 1, 1, 5'd5, 32'h1234, 0, 0, 0);
    // divider-only write
    step(1, 0, 0, 0, 0, 1, 5'd7, 32'hAA);
    chk("div_buffered", 64'(buf_count), 64'd1);
    idle();
    idle();

    // starvation: one buffered result against continuous pipe writes
    div_log.delete();
    step(1, 1, 1, 5'd3, 32'h11, 1, 5'd9, 32'h99);
    for (int i = 0; i < 6; i++)
      step(1, 1, 1, 5'd3, 32'h20 + i, 0, 0, 0);
    chk("starve_pop_cnt", 64'(div_log.size()), 64'd1);
    idle();

    // full buffer: rd=1,2 accepted, rd=3 held until space
    div_log.delete();
    step(1, 1, 1, 5'd10, 32'h1, 1, 5'd1, 32'h101);
    step(1, 1, 1, 5'd10, 32'h2, 1, 5'd2, 32'h102);
    chk("full_count", 64'(buf_count), 64'd2);
    chk("full_ready", 64'(div_ready), 64'd0);
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++)
      step(1, 1, 1, 5'd10, 32'h3 + i, 1, 5'd3, 32'h103);
    chk("held_accepted", 64'(acc), 64'd1);
    for (int i = 0; i < 20; i++)
      step(1, 1, 1, 5'd10, 32'h40 + i, 0, 0, 0);
    chk("order_n", 64'(div_log.size()), 64'd3);
    if (div_log.size() == 3) begin
      chk("order_0", 64'(div_log[0]), 64'd1);
      chk("order_1", 64'(div_log[1]), 64'd2);
      chk("order_2", 64'(div_log[2]), 64'd3);
    end

    // x0 result, then no-write pipe instruction beside a buffered result
    step(1, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD);
    idle();
    step(1, 1, 1, 5'd4, 32'h5, 1, 5'd6, 32'h66);
    step(1, 1, 0, 5'd4, 32'h6, 0, 0, 0);
    idle();

    // reset with a full buffer drops both entries
    step(1, 1, 1, 5'd8, 32'h7, 1, 5'd12, 32'hC);
    step(1, 1, 1, 5'd8, 32'h8, 1, 5'd13, 32'hD);
    chk("pre_rst_count", 64'(buf_count), 64'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_count", 64'(buf_count), 64'd0);
    for (int i = 0; i < 3; i++) idle();

    // same rd twice keeps acceptance order
    step(1, 1, 1, 5'd2, 32'h0, 1, 5'd15, 32'hF1);
    step(1, 1, 1, 5'd2, 32'h0, 1, 5'd15, 32'hF2);
    for (int i = 0; i < 12; i++) idle();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r1, r2;
      r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r2 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 60) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           r1, $urandom, ($urandom_range(0, 2) == 0), r2, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register write-data width.
REQ-002 Parameter RD_WIDTH, default 5, register index width.
REQ-003 Parameter STARVE_LIMIT, default 4, maximum consecutive cycles a buffered divider result may be bypassed by the pipeline.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pipe_valid  input  1  MEM/WB stage holds a valid instruction.
REQ-007 pipe_we  input  1  MEM/WB instruction writes the register file.
REQ-008 pipe_rd  input  RD_WIDTH  MEM/WB destination register.
REQ-009 pipe_data  input  DATA_WIDTH  MEM/WB writeback data.
REQ-010 pipe_hold  output  1  stalls the MEM/WB stage (drives its hold input).
REQ-011 div_valid  input  1  divider presents a completed result.
REQ-012 div_rd  input  RD_WIDTH  divider destination register.
REQ-013 div_data  input  DATA_WIDTH  divider result.
REQ-014 div_ready  output  1  arbiter accepts the divider result this cycle.
REQ-015 rf_we  output  1  register-file write enable.
REQ-016 rf_waddr  output  RD_WIDTH  register-file write address.
REQ-017 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-018 buf_count  output  2  divider results held in the buffer (0..2).

Function
REQ-019 The block SHALL hold divider results in a 2-entry FIFO (rd+data per entry), written on div_valid & div_ready, read from the head only.
REQ-020 div_ready SHALL equal (buf_count < 2), derived from registered count only, never from the current grant.
REQ-021 pipe_req SHALL be pipe_valid & pipe_we; div_req SHALL be buf_count != 0.
REQ-022 urgent SHALL be starve_cnt >= STARVE_LIMIT.
REQ-023 Grant per cycle: pipe_req & !urgent -> pipeline; else div_req -> FIFO head; else none.
REQ-024 A divider grant SHALL pop the FIFO head at the same clock edge; a result reaches the register file no earlier than the cycle after acceptance.
REQ-025 pipe_hold SHALL be pipe_req & divider-granted (combinational); pipe_hold SHALL be 0 when pipe_we=0 or pipe_valid=0.
REQ-026 rf_waddr/rf_wdata SHALL come from the granted source; both SHALL be 0 with no grant.
REQ-027 rf_we SHALL be 1 iff a grant exists and rf_waddr != 0 (x0 writes consume the grant, FIFO still pops, no write).
REQ-028 starve_cnt (width sufficient for STARVE_LIMIT) SHALL increment, saturating at STARVE_LIMIT, on each cycle with div_req and pipeline grant; SHALL clear on any FIFO pop or when buf_count = 0.
REQ-029 Simultaneous push and pop at buf_count=1 SHALL leave buf_count=1 with order preserved; at buf_count=2, no push occurs.
REQ-030 Pointers SHALL wrap modulo 2; buf_count SHALL never exceed 2 or underflow.
REQ-031 Two results with the same rd SHALL write in acceptance order; no merging or reordering.

Reset
REQ-032 On rst_n=0 at a clock edge: buf_count=0, read/write pointers=0, starve_cnt=0; FIFO contents discarded (reset mid-operation drops buffered results).
REQ-033 After reset, with pipe_valid=0: rf_we=0, rf_waddr=0, rf_wdata=0, pipe_hold=0, div_ready=1, buf_count=0.

Verification
REQ-034 Pipe only: pipe_valid=1, pipe_we=1, rd=5, data=0x1234 with empty FIFO -> same cycle rf_we=1, waddr=5, wdata=0x1234, pipe_hold=0.
REQ-035 Divider only: div_valid=1, rd=7, data=0xAA for 1 cycle -> div_ready=1, next cycle buf_count=1 and rf_we=1, waddr=7, wdata=0xAA, following cycle buf_count=0.
REQ-036 Starvation: one divider result buffered, pipeline writes every cycle -> 4 pipeline writes, 5th cycle divider granted with pipe_hold=1, pipeline write resumes next cycle, starve_cnt=0.
REQ-037 Full FIFO: two results accepted while pipeline writes continuously -> buf_count=2, div_ready=0, third div_valid held until pop, then accepted; write order rd=1,2,3.
REQ-038 x0 and no-write: divider result rd=0 -> popped with rf_we=0; pipe_valid=1, pipe_we=0 with FIFO non-empty -> divider granted, pipe_hold=0.
REQ-039 Reset mid-operation: buf_count=2, assert rst_n=0 for one cycle -> buf_count=0, rf_we=0, div_ready=1; no stale entry written afterwards.
